hook_grab_scheduler: RTL

Frame-synchronous controller that sequences the miner's hook through swing, shoot, pull and deliver, and arbitrates which game object the hook grabs when its tip overlaps several objects in the same frame. It sits between the pixel-level drawing-request outputs of the object/hook drawers and the hook motion and object-lifecycle logic. It issues one grab decision per frame and single-cycle remove/score pulses per delivered object.

---
 rtl/hook_grab_scheduler_pkg.sv | 15 +
 rtl/hook_grab_scheduler_if.sv | 38 +++
 rtl/hook_grab_scheduler_arbiter.sv | 31 +++
 rtl/hook_grab_scheduler.sv | 131 +++++++++++++
 4 files changed

// File: rtl/hook_grab_scheduler_pkg.sv
// hook_pkg: shared hook state encoding and retract speed constants
package hook_pkg;

    typedef enum logic [2:0] {
        SWING       = 3'd0,
        SHOOT       = 3'd1,
        PULL_LOADED = 3'd2,
        PULL_EMPTY  = 3'd3,
        DELIVER     = 3'd4
    } hook_state_t;

    localparam logic [3:0] SPEED_FAST = 4'd8;
    localparam logic [3:0] SPEED_SLOW = 4'd2;

endpackage

// File: rtl/hook_grab_scheduler_if.sv
// hook_grab_scheduler_if: pixel requests, motion commands and grab results around the hook scheduler
interface hook_grab_scheduler_if #(
    parameter int N_OBJ = 8
);
    import hook_pkg::*;

    logic                       startOfFrame;
    logic                       shoot_key;
    logic                       hook_at_home;
    logic                       drawing_request_hook;
    logic                       drawing_request_boarders;
    logic [N_OBJ-1:0]           drawing_request_objects;
    logic [N_OBJ-1:0]           obj_heavy;
    hook_state_t                hook_state;
    logic                       swing_en;
    logic                       extend;
    logic                       retract;
    logic [3:0]                 retract_speed;
    logic                       grabbed_valid;
    logic [$clog2(N_OBJ)-1:0]   grabbed_idx;
    logic [N_OBJ-1:0]           obj_remove_pulse;
    logic                       score_pulse;

    modport master (
        output startOfFrame, shoot_key, hook_at_home, drawing_request_hook,
               drawing_request_boarders, drawing_request_objects, obj_heavy,
        input  hook_state, swing_en, extend, retract, retract_speed,
               grabbed_valid, grabbed_idx, obj_remove_pulse, score_pulse
    );

    modport slave (
        input  startOfFrame, shoot_key, hook_at_home, drawing_request_hook,
               drawing_request_boarders, drawing_request_objects, obj_heavy,
        output hook_state, swing_en, extend, retract, retract_speed,
               grabbed_valid, grabbed_idx, obj_remove_pulse, score_pulse
    );

endinterface

// File: rtl/hook_grab_scheduler_arbiter.sv
// hook_grab_arbiter: picks one grab winner from the per-frame hit vector; HOOK_ROUND_ROBIN_EN rotates the search start
module hook_grab_arbiter #(
    parameter int N_OBJ = 8
) (
`ifdef HOOK_ROUND_ROBIN_EN
    input  logic [$clog2(N_OBJ)-1:0] ptr,
`endif
    input  logic [N_OBJ-1:0]         req,
    output logic [$clog2(N_OBJ)-1:0] idx,
    output logic                     valid
);
    localparam int IW = $clog2(N_OBJ);

    // first requester met while scanning upward from the search start, wrapping past the top
    always_comb begin
        idx = '0;
        valid = 1'b0;
        for (int k = 0; k < N_OBJ; k++) begin
`ifdef HOOK_ROUND_ROBIN_EN
            if (!valid && req[IW'((int'(ptr) + k) % N_OBJ)]) begin
                idx = IW'((int'(ptr) + k) % N_OBJ);
`else
            if (!valid && req[IW'(k)]) begin
                idx = IW'(k);
`endif
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hook_grab_scheduler.sv
// hook_grab_scheduler: frame-synchronous hook sequencer with grab arbitration; HOOK_ROUND_ROBIN_EN selects round-robin grabs
module hook_grab_scheduler #(
    parameter int         N_OBJ            = 8,
    parameter int         MAX_SHOOT_FRAMES = 90,
    parameter logic [3:0] SPEED_FAST       = hook_pkg::SPEED_FAST,
    parameter logic [3:0] SPEED_SLOW       = hook_pkg::SPEED_SLOW
) (
    input logic                  clk,
    input logic                  resetN,
    hook_grab_scheduler_if.slave bus
);
    localparam int IW = $clog2(N_OBJ);
    localparam int CW = $clog2(MAX_SHOOT_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_SHOOT_FRAMES - 1);

    hook_pkg::hook_state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_OBJ-1:0] hit_acc, remove, remove_n;
    logic             border_acc, grab_valid, valid_n, score, score_n;
    logic             swing, ext, ret, win_valid;
    logic [3:0]       speed;
    logic [IW-1:0]    grab_idx, idx_n, win_idx;

`ifdef HOOK_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    // search start moves just past each grabbed object so the next shot favours the following index
    always_ff @(posedge clk or negedge resetN)
        if (!resetN)
            rr_ptr <= '0;
        else if (bus.startOfFrame && state == hook_pkg::SHOOT && win_valid)
            rr_ptr <= (win_idx == IW'(N_OBJ - 1)) ? '0 : win_idx + IW'(1);
`endif

    hook_grab_arbiter #(.N_OBJ(N_OBJ)) u_arb (
`ifdef HOOK_ROUND_ROBIN_EN
        .ptr   (rr_ptr),
`endif
        .req   (hit_acc),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // per-frame overlap memory; a hit in the startOfFrame cycle already belongs to the new frame
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            hit_acc <= '0;
            border_acc <= 1'b0;
        end else begin
            hit_acc <= (bus.startOfFrame ? '0 : hit_acc) | ({N_OBJ{bus.drawing_request_hook}} & bus.drawing_request_objects);
            border_acc <= (bus.startOfFrame ? 1'b0 : border_acc) | (bus.drawing_request_hook & bus.drawing_request_boarders);
        end

    // frame decisions: only startOfFrame cycles move the hook, using last frame's overlaps
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        valid_n = grab_valid;
        idx_n = grab_idx;
        remove_n = '0;
        score_n = 1'b0;
        if (bus.startOfFrame)
            case (state)
                hook_pkg::SWING:
                    if (bus.shoot_key) begin
                        state_n = hook_pkg::SHOOT;
                        cnt_n = '0;
                    end
                hook_pkg::SHOOT: begin
                    cnt_n = cnt + CW'(1);
                    if (win_valid) begin
                        state_n = hook_pkg::PULL_LOADED;
                        valid_n = 1'b1;
                        idx_n = win_idx;
                    end else if (border_acc || cnt == CNT_LAST)
                        state_n = hook_pkg::PULL_EMPTY;
                end
                hook_pkg::PULL_LOADED:
                    if (bus.hook_at_home) begin
                        state_n = hook_pkg::DELIVER;
                        remove_n = N_OBJ'(1) << grab_idx;
                        score_n = 1'b1;
                    end
                hook_pkg::PULL_EMPTY:
                    if (bus.hook_at_home)
                        state_n = hook_pkg::SWING;
                hook_pkg::DELIVER: begin
                    state_n = hook_pkg::SWING;
                    valid_n = 1'b0;
                end
                default: state_n = hook_pkg::SWING;
            endcase
    end

    // state, grab record and motion commands all register together, one cycle after the deciding frame edge
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state <= hook_pkg::SWING;
            cnt <= '0;
            grab_valid <= 1'b0;
            grab_idx <= '0;
            remove <= '0;
            score <= 1'b0;
            swing <= 1'b1;
            ext <= 1'b0;
            ret <= 1'b0;
            speed <= SPEED_FAST;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            grab_valid <= valid_n;
            grab_idx <= idx_n;
            remove <= remove_n;
            score <= score_n;
            swing <= state_n == hook_pkg::SWING;
            ext <= state_n == hook_pkg::SHOOT;
            ret <= state_n == hook_pkg::PULL_LOADED || state_n == hook_pkg::PULL_EMPTY;
            speed <= (state_n == hook_pkg::PULL_LOADED && bus.obj_heavy[idx_n]) ? SPEED_SLOW : SPEED_FAST;
        end

    assign bus.hook_state = state;
    assign bus.swing_en = swing;
    assign bus.extend = ext;
    assign bus.retract = ret;
    assign bus.retract_speed = speed;
    assign bus.grabbed_valid = grab_valid;
    assign bus.grabbed_idx = grab_idx;
    assign bus.obj_remove_pulse = remove;
    assign bus.score_pulse = score;

endmodule
